// File: rtl/ir_nec_pkg.sv
// rtl/ir_nec_pkg.sv - shared states, NEC timing windows and drive codes for ir_nec_rx
package ir_nec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_L,
    S_LEAD_H,
    S_BIT_L,
    S_BIT_H,
    S_CHECK
  } state_e;

  localparam logic [13:0] LEAD_L_MIN       = 14'd8000;
  localparam logic [13:0] LEAD_L_MAX       = 14'd10000;
  localparam logic [13:0] LEAD_H_DATA_MIN  = 14'd4000;
  localparam logic [13:0] LEAD_H_DATA_MAX  = 14'd5000;
  localparam logic [13:0] LEAD_H_RPT_MIN   = 14'd1750;
  localparam logic [13:0] LEAD_H_RPT_MAX   = 14'd2750;
  localparam logic [13:0] BIT_L_MIN        = 14'd360;
  localparam logic [13:0] BIT_L_MAX        = 14'd760;
  localparam logic [13:0] BIT0_H_MIN       = 14'd360;
  localparam logic [13:0] BIT0_H_MAX       = 14'd760;
  localparam logic [13:0] BIT1_H_MIN       = 14'd1400;
  localparam logic [13:0] BIT1_H_MAX       = 14'd1900;
  localparam logic [13:0] TIMEOUT_US       = 14'd12000;
  localparam logic [13:0] DUR_SAT          = 14'h3FFF;

  localparam logic [2:0] DRV_STOP  = 3'd0;
  localparam logic [2:0] DRV_FWD   = 3'd1;
  localparam logic [2:0] DRV_BACK  = 3'd2;
  localparam logic [2:0] DRV_LEFT  = 3'd3;
  localparam logic [2:0] DRV_RIGHT = 3'd4;

  function automatic logic in_win(input logic [13:0] d, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_nec_rx_tick.sv
// rtl/ir_nec_rx_tick.sv - 1 us and 1 ms strobe generator (module ir_tick_gen)
module ir_tick_gen #(
  parameter int CLK_PER_US = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_us_o,
  output logic tick_ms_o
);

  localparam logic [15:0] US_LAST = 16'(CLK_PER_US - 1);

  logic [15:0] us_cnt_q;
  logic [9:0]  ms_cnt_q;
  logic        tick_us_q;
  logic        tick_ms_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt_q  <= '0;
      ms_cnt_q  <= '0;
      tick_us_q <= 1'b0;
      tick_ms_q <= 1'b0;
    end else begin
      if (us_cnt_q == US_LAST) begin
        us_cnt_q  <= '0;
        tick_us_q <= 1'b1;
      end else begin
        us_cnt_q  <= us_cnt_q + 16'd1;
        tick_us_q <= 1'b0;
      end
      if (tick_us_q) begin
        ms_cnt_q <= (ms_cnt_q == 10'd999) ? 10'd0 : ms_cnt_q + 10'd1;
      end
      tick_ms_q <= tick_us_q && (ms_cnt_q == 10'd999);
    end
  end

  assign tick_us_o = tick_us_q;
  assign tick_ms_o = tick_ms_q;

endmodule

// File: rtl/ir_nec_rx.sv
// rtl/ir_nec_rx.sv - NEC IR frame decoder producing a held 3-bit drive command
module ir_nec_rx
  import ir_nec_pkg::*;
#(
  parameter int         CLK_PER_US = 50,
  parameter int         HOLD_MS    = 120,
  parameter logic [7:0] KEY_FWD    = 8'h18,
  parameter logic [7:0] KEY_BACK   = 8'h52,
  parameter logic [7:0] KEY_LEFT   = 8'h08,
  parameter logic [7:0] KEY_RIGHT  = 8'h5A,
  parameter logic [7:0] KEY_STOP   = 8'h1C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_in,
  output logic [2:0] data,
  output logic       data_valid,
  output logic       repeat_pulse,
  output logic       frame_err,
  output logic [7:0] addr,
  output logic [7:0] cmd
);

  localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_MS);

  logic tick_us, tick_ms;

  ir_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_us_o (tick_us),
    .tick_ms_o (tick_ms)
  );

  // Synchronizer flops idle high so reset does not fabricate a falling edge
  logic sync1_q, sync2_q, prev_q;
  logic fall, rise, any_edge;

  assign fall     = prev_q & ~sync2_q;
  assign rise     = ~prev_q & sync2_q;
  assign any_edge = fall | rise;

  state_e      state_q, state_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [31:0] sr_q, sr_d;
  logic        rpt_q, rpt_d;
  logic [13:0] dur_q;
  logic [15:0] hold_q;
  logic        have_frame_q;
  logic [2:0]  data_q;
  logic [7:0]  addr_q, cmd_q;
  logic        data_valid_q, repeat_q, frame_err_q;

  logic reject, rpt_end, last_bit, frame_ok, frame_bad, rpt_ok;

  function automatic logic [2:0] map_cmd(input logic [7:0] c);
    if (c == KEY_FWD)   return DRV_FWD;
    if (c == KEY_BACK)  return DRV_BACK;
    if (c == KEY_LEFT)  return DRV_LEFT;
    if (c == KEY_RIGHT) return DRV_RIGHT;
    if (c == KEY_STOP)  return DRV_STOP;
    return DRV_STOP;
  endfunction

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    rpt_d     = rpt_q;
    reject    = 1'b0;
    rpt_end   = 1'b0;
    last_bit  = 1'b0;
    case (state_q)
      S_IDLE: if (fall) state_d = S_LEAD_L;
      S_LEAD_L: begin
        if (rise) state_d = in_win(dur_q, LEAD_L_MIN, LEAD_L_MAX) ? S_LEAD_H : S_IDLE;
      end
      S_LEAD_H: begin
        if (fall) begin
          if (in_win(dur_q, LEAD_H_DATA_MIN, LEAD_H_DATA_MAX)) begin
            state_d   = S_BIT_L;
            bit_idx_d = 5'd0;
            rpt_d     = 1'b0;
          end else if (in_win(dur_q, LEAD_H_RPT_MIN, LEAD_H_RPT_MAX)) begin
            state_d = S_BIT_L;
            rpt_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
            reject  = 1'b1;
          end
        end
      end
      S_BIT_L: begin
        // A repeat code reuses BIT_L to wait for the end of its stop burst
        if (rise) begin
          if (rpt_q) begin
            state_d = S_IDLE;
            rpt_end = 1'b1;
          end else if (in_win(dur_q, BIT_L_MIN, BIT_L_MAX)) begin
            state_d = S_BIT_H;
          end else begin
            state_d = S_IDLE;
            reject  = 1'b1;
          end
        end
      end
      S_BIT_H: begin
        if (fall) begin
          if (in_win(dur_q, BIT0_H_MIN, BIT0_H_MAX) || in_win(dur_q, BIT1_H_MIN, BIT1_H_MAX)) begin
            sr_d = {in_win(dur_q, BIT1_H_MIN, BIT1_H_MAX), sr_q[31:1]};
            if (bit_idx_q == 5'd31) begin
              state_d  = S_CHECK;
              last_bit = 1'b1;
            end else begin
              state_d   = S_BIT_L;
              bit_idx_d = bit_idx_q + 5'd1;
            end
          end else begin
            state_d = S_IDLE;
            reject  = 1'b1;
          end
        end
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && !any_edge && (dur_q >= TIMEOUT_US)) begin
      state_d = S_IDLE;
      reject  = 1'b1;
    end
  end

  // The complete word is judged as it is assembled so the result lands 3 clk after the pin edge
  assign frame_ok  = last_bit && (sr_d[15:8] == ~sr_d[7:0]) && (sr_d[31:24] == ~sr_d[23:16]);
  assign frame_bad = last_bit && !frame_ok;
  assign rpt_ok    = rpt_end && have_frame_q && (hold_q != 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      dur_q     <= '0;
      state_q   <= S_IDLE;
      bit_idx_q <= '0;
      sr_q      <= '0;
      rpt_q     <= 1'b0;
    end else begin
      sync1_q   <= ir_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      if (any_edge) dur_q <= '0;
      else if (tick_us && (dur_q != DUR_SAT)) dur_q <= dur_q + 14'd1;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      sr_q      <= sr_d;
      rpt_q     <= rpt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid_q <= 1'b0;
      repeat_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      data_q       <= DRV_STOP;
      addr_q       <= '0;
      cmd_q        <= '0;
      have_frame_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      data_valid_q <= frame_ok;
      repeat_q     <= rpt_ok;
      frame_err_q  <= reject | frame_bad;
      // A reload outranks an expiry landing in the same cycle
      if (frame_ok) begin
        addr_q       <= sr_d[7:0];
        cmd_q        <= sr_d[23:16];
        data_q       <= map_cmd(sr_d[23:16]);
        have_frame_q <= 1'b1;
        hold_q       <= HOLD_RELOAD;
      end else if (rpt_ok) begin
        hold_q <= HOLD_RELOAD;
      end else if (tick_ms && (hold_q != 16'd0)) begin
        hold_q <= hold_q - 16'd1;
        if (hold_q == 16'd1) begin
          data_q       <= DRV_STOP;
          have_frame_q <= 1'b0;
        end
      end
    end
  end

  assign data         = data_q;
  assign data_valid   = data_valid_q;
  assign repeat_pulse = repeat_q;
  assign frame_err    = frame_err_q;
  assign addr         = addr_q;
  assign cmd          = cmd_q;

endmodule

// File: tb/tb_ir_nec_rx.sv
// tb/tb_ir_nec_rx.sv - directed bench for ir_nec_rx; one clk per microsecond
module tb_ir_nec_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ir_in = 1'b1;
  logic [2:0] data;
  logic       data_valid, repeat_pulse, frame_err;
  logic [7:0] addr, cmd;

  int total = 0;
  int bad   = 0;
  int dv_cnt = 0;
  int rp_cnt = 0;
  int fe_cnt = 0;

  ir_nec_rx #(.CLK_PER_US(1), .HOLD_MS(120)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ir_in        (ir_in),
    .data         (data),
    .data_valid   (data_valid),
    .repeat_pulse (repeat_pulse),
    .frame_err    (frame_err),
    .addr         (addr),
    .cmd          (cmd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (repeat_pulse) rp_cnt++;
    if (frame_err) fe_cnt++;
    if (int'(data_valid) + int'(repeat_pulse) + int'(frame_err) > 1) begin
      total++;
      bad++;
      $error("FAIL pulse_overlap observed=%b%b%b expected=at most one", data_valid, repeat_pulse,
             frame_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lo(input int n);
    ir_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic hi(input int n);
    ir_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      lo(560);
      hi(w[i] ? 1690 : 560);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] cn);
    logic [31:0] w;
    w = {cn, c, ~a, a};
    lo(9000);
    hi(4500);
    send_bits(w, 32);
    lo(560);
    hi(10);
  endtask

  task automatic send_repeat();
    lo(9000);
    hi(2250);
    lo(560);
    hi(10);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("reset_data", 32'(data), 32'd0);
    check("reset_pulses", {29'd0, data_valid, repeat_pulse, frame_err}, 32'd0);
    check("reset_addr_cmd", {16'd0, addr, cmd}, 32'd0);
    rst_n = 1'b1;
    hi(1000);

    send_frame(8'h00, 8'h18, 8'hE7);
    check("fwd_dv_count", 32'(dv_cnt), 32'd1);
    check("fwd_data", 32'(data), 32'd1);
    check("fwd_addr", 32'(addr), 32'h00);
    check("fwd_cmd", 32'(cmd), 32'h18);
    check("fwd_no_err", 32'(fe_cnt), 32'd0);

    hi(40000);
    for (int k = 1; k <= 3; k++) begin
      send_repeat();
      check("rpt_count", 32'(rp_cnt), 32'(k));
      check("rpt_data_held", 32'(data), 32'd1);
      if (k < 3) hi(96000);
    end
    hi(100000);
    check("hold_still_1", 32'(data), 32'd1);
    hi(21000);
    check("hold_expired", 32'(data), 32'd0);
    check("rpt_no_err", 32'(fe_cnt), 32'd0);

    hi(1000);
    send_frame(8'h00, 8'h52, 8'hAC);
    check("biterr_fe", 32'(fe_cnt), 32'd1);
    check("biterr_no_dv", 32'(dv_cnt), 32'd1);
    check("biterr_data", 32'(data), 32'd0);
    check("biterr_cmd", 32'(cmd), 32'h18);

    hi(1000);
    send_frame(8'h00, 8'h18, 8'hE7);
    check("fwd2_data", 32'(data), 32'd1);
    hi(1000);
    send_frame(8'h00, 8'h45, 8'hBA);
    check("unmapped_dv", 32'(dv_cnt), 32'd3);
    check("unmapped_cmd", 32'(cmd), 32'h45);
    check("unmapped_data", 32'(data), 32'd0);

    hi(1000);
    lo(5000);
    hi(15000);
    check("glitch_no_err", 32'(fe_cnt), 32'd1);

    lo(9000);
    hi(4500);
    send_bits({8'hF7, 8'h08, 8'hFF, 8'h00}, 10);
    lo(560);
    hi(11900);
    check("cut_before_timeout", 32'(fe_cnt), 32'd1);
    hi(200);
    check("cut_timeout_err", 32'(fe_cnt), 32'd2);

    hi(1000);
    send_frame(8'h00, 8'h08, 8'hF7);
    check("left_data", 32'(data), 32'd3);
    check("left_dv", 32'(dv_cnt), 32'd4);

    hi(1000);
    lo(9000);
    hi(4500);
    send_bits({8'hA5, 8'h5A, 8'hFF, 8'h00}, 20);
    rst_n = 1'b0;
    #1;
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_addr_cmd", {16'd0, addr, cmd}, 32'd0);
    check("midrst_pulses", {29'd0, data_valid, repeat_pulse, frame_err}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    hi(1000);
    send_frame(8'h00, 8'h5A, 8'hA5);
    check("right_data", 32'(data), 32'd4);
    check("right_cmd", 32'(cmd), 32'h5A);
    check("right_dv", 32'(dv_cnt), 32'd5);
    check("final_err_count", 32'(fe_cnt), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_nec_rx.md
Name: ir_nec_rx

Overview:
- Infrared remote receiver for the car. Decodes NEC frames from the IR receiver module output and produces the 3-bit drive command consumed by the motor-control block.
- Holds the command while the remote's repeat codes keep arriving. Releases to STOP (0) when the key is released or the signal is lost.
- Sits between the IR demodulator pin and the motor-control block's data input.

Parameters:
- CLK_PER_US, 50, clk cycles per microsecond; drives the 1 us tick.
- HOLD_MS, 120, time after the last valid frame or repeat before data returns to 0.
- KEY_FWD, 8'h18, NEC command mapped to data=1.
- KEY_BACK, 8'h52, NEC command mapped to data=2.
- KEY_LEFT, 8'h08, NEC command mapped to data=3.
- KEY_RIGHT, 8'h5A, NEC command mapped to data=4.
- KEY_STOP, 8'h1C, NEC command mapped to data=0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ir_in  in  1  raw demodulated IR; active-low (0 = carrier burst); asynchronous to clk
- data  out  3  drive command 0..4
- data_valid  out  1  one-cycle pulse on each accepted full frame
- repeat_pulse  out  1  one-cycle pulse on each accepted repeat code
- frame_err  out  1  one-cycle pulse on a rejected frame
- addr  out  8  address byte of the last accepted frame
- cmd  out  8  command byte of the last accepted frame

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, hold timer expired, have_frame = 0.
- Input conditioning:
  - ir_in passes through a 2-flop synchronizer.
  - Falling and rising edges are detected on the synchronized signal.
- Duration counter:
  - 14-bit microsecond counter, clears on every edge, saturates at 16383.
  - Advances on a 1 us tick from the prescaler.
- FSM states: IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H, CHECK.
- IDLE: on falling edge go to LEAD_L.
- LEAD_L (low duration measured at rising edge):
  - 8000–10000 us -> LEAD_H.
  - Otherwise -> IDLE, no error (treated as noise).
- LEAD_H (high duration measured at falling edge):
  - 4000–5000 us -> BIT_L, bit index 0.
  - 1750–2750 us -> repeat path: wait for the stop burst rising edge, then IDLE. repeat_pulse fires only if have_frame=1 and the hold timer has not expired.
  - Otherwise -> frame_err, IDLE.
- BIT_L (low measured at rising edge):
  - 360–760 us -> BIT_H.
  - Otherwise -> frame_err, IDLE.
- BIT_H (high measured at falling edge):
  - 360–760 us -> bit 0; 1400–1900 us -> bit 1.
  - Otherwise -> frame_err, IDLE.
  - The bit shifts in LSB-first into a 32-bit register as {cmd_n, cmd, addr_n, addr}.
  - After bit 31 -> CHECK; else bit index+1, back to BIT_L.
- CHECK (one cycle):
  - Accepted only if addr_n == ~addr and cmd_n == ~cmd.
  - Pass: addr/cmd latched, data_valid pulses, data updated, have_frame=1, hold timer reloaded. Return to IDLE, where the stop burst's rising edge is ignored.
  - Fail: frame_err pulses; data, addr, cmd unchanged; IDLE.
- Command mapping:
  - KEY_FWD->1, KEY_BACK->2, KEY_LEFT->3, KEY_RIGHT->4, KEY_STOP->0.
  - Any other valid command -> 0 (fail-safe stop); data_valid still pulses.
- Timeout: in any non-IDLE state, 12000 us without an edge -> frame_err, IDLE.
- Latency: data/data_valid/repeat_pulse assert 3 clk after the qualifying ir_in edge at the pin (2 sync + 1 register).
- Hold timer:
  - Millisecond counter reloaded to HOLD_MS on each accepted frame or repeat.
  - On expiry data <= 0 and have_frame <= 0. No pulse is generated.
- Simultaneous events: a reload in the same cycle as expiry wins (data keeps the new value).
- Reset mid-frame: immediate return to reset values; the next complete frame decodes normally.
- Pulses never overlap: at most one of data_valid, repeat_pulse, frame_err per cycle.

Decomposition:
- Package ir_nec_pkg holds:
  - FSM state enum.
  - Timing window constants: LEAD_L min/max, LEAD_H data/repeat min/max, BIT_L, BIT0_H, BIT1_H, TIMEOUT_US.
  - Drive command codes: STOP=0, FWD=1, BACK=2, LEFT=3, RIGHT=4.
- Sub-module ir_tick_gen: produces the 1 us and 1 ms strobes from CLK_PER_US.
- The FSM, shift register, checker, mapper and hold timer stay in ir_nec_rx.

Test Plan:
- Full frame addr=0x00, cmd=0x18 (9 ms/4.5 ms leader, 560 us bursts) -> data_valid one pulse, data=1, addr=0x00, cmd=0x18, frame_err stays 0.
- After that frame, repeat codes every 108 ms for 3 repeats, then silence -> 3 repeat_pulse, data=1 throughout, data=0 by 120 ms after the last repeat.
- Frame with cmd=0x52 and cmd_n=0xAC (bit error) -> frame_err pulse, no data_valid, data/cmd unchanged.
- Valid frame cmd=0x45 (unmapped) while data=1 -> data_valid pulse, cmd=0x45, data=0.
- Two malformed inputs:
  - 5 ms low glitch -> no frame_err, FSM stays IDLE.
  - Frame cut after bit 10 -> frame_err 12 ms after the last edge.
  - A following valid KEY_LEFT frame -> data=3.
- rst_n pulsed low at bit 20 of a KEY_RIGHT frame -> all outputs 0 immediately; the next full KEY_RIGHT frame -> data=4.
